mem_byte_sequencer: RTL
=======================

# mem_byte_sequencer

Load/store sequencer between the MEM-stage datapath and the byte-wide (8-bit) data memory. It splits each RV32I load or store into 1, 2 or 4 single-byte memory accesses in little-endian order. It assembles and sign- or zero-extends load data, and stalls the pipeline until the access completes. The memory has combinational read and writes on the clock edge, so each byte takes exactly one cycle.

## Interface

Parameters:
- ADDRESS_WIDTH, 32: width of byte addresses on both the pipeline and memory sides.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset. Synchronous, active-low; sampled on the rising edge of clk.
- req_valid  in  1  MEM stage holds a load or store. Held stable together with the other req_* inputs while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3. Bits [1:0]: 00 = byte, 01 = half, 10 = word, 11 = illegal. Bit [2] = unsigned (loads only).
- req_addr  in  ADDRESS_WIDTH  byte address of the lowest byte.
- req_wdata  in  32  store data. Byte k is bits [8k+7:8k].
- stall  out  1  freeze the pipeline this cycle.
- done  out  1  one-cycle pulse: the access has completed.
- err  out  1  valid with done; illegal funct3.
- rdata  out  32  extended load result. Valid while done=1 and held until the next done.
- mem_we  out  1  write enable to the data memory.
- mem_a  out  ADDRESS_WIDTH  byte address to the data memory.
- mem_wd  out  8  write byte to the data memory.
- mem_rd  in  8  read byte from the data memory (combinational on mem_a).

## Operation

The block is a three-state FSM: IDLE, ACCESS, DONE.

Registered state:
- base address, count (2 bits), nbytes-1, we, unsigned flag, wdata, illegal flag
- 32-bit assembly buffer, rdata

State transitions:
- **IDLE:** if req_valid=1, latch the req_* inputs and clear count. A legal request goes to ACCESS. An illegal request (funct3[1:0]=11, or a store with funct3[2]=1) sets the illegal flag and goes directly to DONE with no memory access. If req_valid=0, stay in IDLE.
- **ACCESS:** drive the byte access for the current count (see below). When count = nbytes-1 go to DONE; otherwise increment count.
- **DONE:** done=1 for this single cycle, then return to IDLE. req_valid is ignored in DONE, because it still reflects the completing instruction.

Byte access in ACCESS:
- mem_a = base + count, modulo 2^ADDRESS_WIDTH (address wrap is allowed).
- mem_we = we.
- mem_wd = wdata byte[count].
- On a load, mem_rd is captured into buffer byte[count].

Load result, written into rdata at the ACCESS→DONE transition:
- Byte loads: buffer bits [7:0], sign- or zero-extended per the unsigned flag.
- Half loads: buffer bits [15:0], extended the same way.
- Word loads: the full buffer.
- Illegal requests: rdata = 0 and err = 1 in DONE.
- Stores leave rdata unchanged.

Output rules:
- stall = (IDLE and req_valid) or ACCESS. It is combinational and 0 in DONE.
- Outside ACCESS: mem_we=0, mem_a=0, mem_wd=0.
- Misaligned addresses are legal. There is no alignment check and no trap.

## Timing

- **Reset:** state = IDLE, count = 0, buffer = 0, rdata = 0, done = 0, err = 0, mem_we = 0, mem_a = 0, mem_wd = 0. While IDLE after reset, stall follows req_valid.
- **Latency:** request sampled in IDLE at cycle 0; ACCESS occupies cycles 1..n (n = 1, 2 or 4); done=1 in cycle n+1.
  - Stall cycles: n+1, i.e. 2 for byte, 3 for half, 5 for word.
  - Illegal requests: 1 stall cycle, done in cycle 1.
- **Back-to-back:** the earliest next request is sampled in the cycle after DONE, so there is no overlap between requests.
- **Writes** commit at the rising edge that ends each ACCESS cycle.
- **Reset mid-operation:** the FSM aborts to IDLE with no done pulse. Bytes already written stay written.
- req inputs that change while stall=1 are a protocol violation. The block uses its latched copies.

## Test plan

- **Store word then load word:** SW 0xDEADBEEF @0x00010000, then LW @0x00010000.
  - SW writes 0xEF, 0xBE, 0xAD, 0xDE to 0x10000–0x10003 on 4 consecutive edges.
  - LW returns rdata = 0xDEADBEEF.
  - Each access gives 5 stall cycles, then a done pulse.
- **Signed/unsigned byte loads** (after the store above):
  - LB @0x10003 → 0xFFFFFFDE.
  - LBU @0x10003 → 0x000000DE.
  - Each gives 2 stall cycles.
- **Misaligned half loads:**
  - LH @0x10001 → 0xFFFFADBE.
  - LHU @0x10001 → 0x0000ADBE.
  - Each gives 3 stall cycles.
- **Address wrap:** SW 0x11223344 @0xFFFFFFFE → mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001 with data 44, 33, 22, 11.
- **Illegal funct3:** funct3 = 011 load, and funct3 = 100 store.
  - mem_we is never asserted.
  - err = 1 and done = 1 in cycle 1; rdata = 0 for the load.
- **Reset mid-store:** rst_n=0 after 2 ACCESS cycles of SW 0xCAFEF00D @0x20.
  - Only 0x0D @0x20 and 0xF0 @0x21 are written.
  - No done pulse; state returns to IDLE and all outputs return to their reset values.

Source files
------------

// File: rtl/mem_byte_sequencer.sv
// Purpose : splits RV32I loads/stores into little-endian single-byte memory accesses.
// Latency : 1 sampling cycle + 1/2/4 byte cycles, done pulses one cycle later; illegal ops done in cycle 1.
// Backpress: holds stall high until the access finishes; requester keeps req_* stable while stalled.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/we/funct3/addr/wdata  MEM-stage request, held stable while stall=1
//   stall, done, err, rdata     pipeline freeze, completion pulse, illegal flag, extended load data
//   mem_we/mem_a/mem_wd/mem_rd  byte-wide data memory (combinational read, edge write)

module mem_byte_sequencer #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     stall,
  output logic                     done,
  output logic                     err,
  output logic [31:0]              rdata,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_a,
  output logic [7:0]               mem_wd,
  input  logic [7:0]               mem_rd
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Latched copy of the request; the live req_* inputs are not trusted after sampling.
  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] base;
    logic [1:0]               nbm1;   // number of bytes minus one
    logic                     we;
    logic                     uns;
    logic [31:0]              wdata;
    logic                     ill;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        illegal;

  assign rdata = rdata_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    count_d = count_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    illegal = 1'b0;
    stall   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    mem_we  = 1'b0;
    mem_a   = '0;
    mem_wd  = '0;

    case (state_q)
      S_IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          // funct3[2] (unsigned) has no meaning for stores.
          illegal    = (req_funct3[1:0] == 2'b11) || (req_we && req_funct3[2]);
          req_d.base = req_addr;
          req_d.we   = req_we;
          req_d.uns  = req_funct3[2];
          req_d.wdata = req_wdata;
          req_d.ill  = illegal;
          case (req_funct3[1:0])
            2'b00:   req_d.nbm1 = 2'd0;
            2'b01:   req_d.nbm1 = 2'd1;
            default: req_d.nbm1 = 2'd3;
          endcase
          count_d = 2'd0;
          if (illegal) begin
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end

      S_ACCESS: begin
        stall  = 1'b1;
        mem_we = req_q.we;
        // Plain modular add: accesses may wrap past the top of the address space.
        mem_a  = req_q.base + ADDRESS_WIDTH'(count_q);
        mem_wd = req_q.wdata[{count_q, 3'b000} +: 8];
        if (!req_q.we) begin
          buf_d[{count_q, 3'b000} +: 8] = mem_rd;
        end
        if (count_q == req_q.nbm1) begin
          state_d = S_DONE;
          // Extend from buf_d so the byte captured this cycle is included.
          if (!req_q.we) begin
            case (req_q.nbm1)
              2'd0:    rdata_d = {{24{~req_q.uns & buf_d[7]}}, buf_d[7:0]};
              2'd1:    rdata_d = {{16{~req_q.uns & buf_d[15]}}, buf_d[15:0]};
              default: rdata_d = buf_d;
            endcase
          end
        end else begin
          count_d = count_q + 2'd1;
        end
      end

      S_DONE: begin
        // req_valid still shows the completing instruction here, so it is ignored.
        done    = 1'b1;
        err     = req_q.ill;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      count_q <= 2'd0;
      buf_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      count_q <= count_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
